mux_tree_pipelined: RTL and testbench

//  Parametrised N:1 data multiplexer built as a log2(N)-level tree of registered 2:1 stages.

---
 rtl/mux_tree_pipelined_pkg.sv | 30 +++
 rtl/mux2_stage.sv | 72 +++++++
 rtl/mux_tree_pipelined.sv | 142 ++++++++++++++
 tb/tb_mux_tree_pipelined.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_tree_pipelined_pkg.sv
// ============================================================================
// Module      : mux_pkg
// Description : Shared types and helpers for the pipelined mux tree.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_pkg;

    // Upper bound on select width carried in the tag (covers up to 65536 channels)
    localparam int MAX_SEL_W = 16;

    typedef struct packed {
        logic [MAX_SEL_W-1:0] sel;
        logic                 err;
    } mux_tag_t;

    // Ceiling log2 for n >= 2
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux2_stage.sv
// ============================================================================
// Module      : mux2_stage
// Description : One 2:1 level of the mux tree; data, tag and valid travel
//               together, optionally registered with a global stall.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux2_stage
    import mux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LVL    = 0,
    parameter int REG    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [DATA_W-1:0] a_data,
    input  logic [DATA_W-1:0] b_data,
    input  mux_tag_t          a_tag,
    input  mux_tag_t          b_tag,
    input  logic              a_valid,
    input  logic              b_valid,
    output logic [DATA_W-1:0] q_data,
    output mux_tag_t          q_tag,
    output logic              q_valid
);

    logic              w_pick_b;
    logic [DATA_W-1:0] w_data;
    mux_tag_t          w_tag;
    logic              w_valid;

    // Both children carry the same beat's tag, so the whole record is muxed
    assign w_pick_b = a_tag.sel[LVL];
    assign w_data   = w_pick_b ? b_data  : a_data;
    assign w_tag    = w_pick_b ? b_tag   : a_tag;
    assign w_valid  = w_pick_b ? b_valid : a_valid;

    if (REG != 0) begin : g_reg
        logic [DATA_W-1:0] r_data;
        mux_tag_t          r_tag;
        logic              r_valid;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_data  <= '0;
                r_tag   <= '0;
                r_valid <= 1'b0;
            end else if (!stall) begin
                r_data  <= w_data;
                r_tag   <= w_tag;
                r_valid <= w_valid;
            end
        end

        assign q_data  = r_data;
        assign q_tag   = r_tag;
        assign q_valid = r_valid;
    end else begin : g_comb
        logic w_unused_ctrl;
        assign w_unused_ctrl = clk ^ rst ^ stall;

        assign q_data  = w_data;
        assign q_tag   = w_tag;
        assign q_valid = w_valid;
    end

endmodule

`default_nettype wire

// File: rtl/mux_tree_pipelined.sv
// ============================================================================
// Module      : mux_tree_pipelined
// Description : Parametrised N:1 mux built as a log2(N)-level tree of 2:1
//               stages with valid/ready flow control and select tagging.
//               Optional auto-scan select enabled by macro MUX_SCAN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_tree_pipelined
    import mux_pkg::*;
#(
    parameter int  N_CH     = 8,
    parameter int  DATA_W   = 8,
    parameter int  PIPE_ALL = 1,
    localparam int LEVELS   = clog2(N_CH),
    localparam int SEL_W    = LEVELS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH*DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   scan_en,
    output logic [DATA_W-1:0]      out_data,
    output logic [SEL_W-1:0]       out_sel,
    output logic                   out_err,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int LEAVES = 1 << LEVELS;

    logic              w_stall;
    logic              w_accept;
    logic [SEL_W-1:0]  w_sel;
    mux_tag_t          w_in_tag;

    // Heap-ordered tree: node 1 is the root, nodes LEAVES..2*LEAVES-1 are leaves
    logic [DATA_W-1:0] w_node_data  [1:2*LEAVES-1];
    mux_tag_t          w_node_tag   [1:2*LEAVES-1];
    logic              w_node_valid [1:2*LEAVES-1];

    // The whole pipeline freezes on a downstream stall, even if inner stages are empty
    assign w_stall  = out_valid && !out_ready;
    assign in_ready = !w_stall;
    assign w_accept = in_valid && in_ready;

`ifdef MUX_SCAN_EN
    logic [SEL_W-1:0] r_scan_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt <= '0;
        end else if (w_accept && scan_en) begin
            r_scan_cnt <= (r_scan_cnt == SEL_W'(N_CH - 1)) ? '0 : r_scan_cnt + SEL_W'(1);
        end
    end

    assign w_sel = scan_en ? r_scan_cnt : in_sel;
`else
    logic w_unused_scan;
    assign w_unused_scan = scan_en;
    assign w_sel         = in_sel;
`endif

    always_comb begin
        w_in_tag                 = '0;
        w_in_tag.sel[SEL_W-1:0]  = w_sel;
        w_in_tag.err             = (32'(w_sel) >= 32'(N_CH));
    end

    for (genvar k = 0; k < LEAVES; k++) begin : g_leaf
        if (k < N_CH) begin : g_ch
            assign w_node_data[LEAVES+k] = in_data[k*DATA_W +: DATA_W];
        end else begin : g_pad
            assign w_node_data[LEAVES+k] = '0;
        end
        assign w_node_tag[LEAVES+k]   = w_in_tag;
        assign w_node_valid[LEAVES+k] = w_accept;
    end

    // Node i sits floor(log2 i) levels below the root and steers on select bit LEVELS-1-that
    for (genvar i = 1; i < LEAVES; i++) begin : g_node
        mux2_stage #(
            .DATA_W (DATA_W),
            .LVL    (LEVELS - clog2(i + 1)),
            .REG    ((PIPE_ALL != 0) ? 1 : 0)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .stall   (w_stall),
            .a_data  (w_node_data[2*i]),
            .b_data  (w_node_data[2*i+1]),
            .a_tag   (w_node_tag[2*i]),
            .b_tag   (w_node_tag[2*i+1]),
            .a_valid (w_node_valid[2*i]),
            .b_valid (w_node_valid[2*i+1]),
            .q_data  (w_node_data[i]),
            .q_tag   (w_node_tag[i]),
            .q_valid (w_node_valid[i])
        );
    end

    logic w_unused_tag;
    assign w_unused_tag = |w_node_tag[1].sel;

    if (PIPE_ALL != 0) begin : g_out_direct
        assign out_data  = w_node_data[1];
        assign out_sel   = w_node_tag[1].sel[SEL_W-1:0];
        assign out_err   = w_node_tag[1].err;
        assign out_valid = w_node_valid[1];
    end else begin : g_out_reg
        logic [DATA_W-1:0] r_data;
        logic [SEL_W-1:0]  r_sel;
        logic              r_err;
        logic              r_valid;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_data  <= '0;
                r_sel   <= '0;
                r_err   <= 1'b0;
                r_valid <= 1'b0;
            end else if (!w_stall) begin
                r_data  <= w_node_data[1];
                r_sel   <= w_node_tag[1].sel[SEL_W-1:0];
                r_err   <= w_node_tag[1].err;
                r_valid <= w_node_valid[1];
            end
        end

        assign out_data  = r_data;
        assign out_sel   = r_sel;
        assign out_err   = r_err;
        assign out_valid = r_valid;
    end

endmodule

`default_nettype wire

// File: tb/tb_mux_tree_pipelined.sv
// ============================================================================
// Module      : tb_mux_tree_pipelined
// Description : Scoreboard bench for mux_tree_pipelined (8ch piped, 6ch piped,
//               8ch output-registered). Scan test built when MUX_SCAN_EN set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_tree_pipelined;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // 8 channels, fully pipelined
    logic [63:0] m_in_data;
    logic [2:0]  m_in_sel;
    logic        m_in_valid, m_in_ready, m_scan_en;
    logic [7:0]  m_out_data;
    logic [2:0]  m_out_sel;
    logic        m_out_err, m_out_valid, m_out_ready;

    // 6 channels, fully pipelined (padded tree)
    logic [47:0] s_in_data;
    logic [2:0]  s_in_sel;
    logic        s_in_valid, s_in_ready;
    logic [7:0]  s_out_data;
    logic [2:0]  s_out_sel;
    logic        s_out_err, s_out_valid, s_out_ready;

    // 8 channels, output register only
    logic [63:0] p_in_data;
    logic [2:0]  p_in_sel;
    logic        p_in_valid, p_in_ready;
    logic [7:0]  p_out_data;
    logic [2:0]  p_out_sel;
    logic        p_out_err, p_out_valid, p_out_ready;

    mux_tree_pipelined #(.N_CH(8), .DATA_W(8), .PIPE_ALL(1)) u_dut (
        .clk(clk), .rst(rst), .in_data(m_in_data), .in_sel(m_in_sel),
        .in_valid(m_in_valid), .in_ready(m_in_ready), .scan_en(m_scan_en),
        .out_data(m_out_data), .out_sel(m_out_sel), .out_err(m_out_err),
        .out_valid(m_out_valid), .out_ready(m_out_ready)
    );

    mux_tree_pipelined #(.N_CH(6), .DATA_W(8), .PIPE_ALL(1)) u_dut6 (
        .clk(clk), .rst(rst), .in_data(s_in_data), .in_sel(s_in_sel),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .scan_en(1'b0),
        .out_data(s_out_data), .out_sel(s_out_sel), .out_err(s_out_err),
        .out_valid(s_out_valid), .out_ready(s_out_ready)
    );

    mux_tree_pipelined #(.N_CH(8), .DATA_W(8), .PIPE_ALL(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_data(p_in_data), .in_sel(p_in_sel),
        .in_valid(p_in_valid), .in_ready(p_in_ready), .scan_en(1'b0),
        .out_data(p_out_data), .out_sel(p_out_sel), .out_err(p_out_err),
        .out_valid(p_out_valid), .out_ready(p_out_ready)
    );

    typedef struct {
        logic [7:0] d;
        logic [2:0] s;
        logic       e;
        int         c;
    } exp_t;

    exp_t q_m[$];
    exp_t q_s[$];
    exp_t q_p[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Each step is one cycle: drive at the falling edge, settle, report handshakes
    task automatic step_m(input logic v, input logic [2:0] sel, input logic ordy,
                          output logic acc, output logic del);
        cyc++;
        m_in_valid = v; m_in_sel = sel; m_out_ready = ordy;
        #1;
        acc = m_in_valid && m_in_ready;
        del = m_out_valid && m_out_ready;
    endtask

    task automatic step_s(input logic v, input logic [2:0] sel, input logic ordy,
                          output logic acc, output logic del);
        cyc++;
        s_in_valid = v; s_in_sel = sel; s_out_ready = ordy;
        #1;
        acc = s_in_valid && s_in_ready;
        del = s_out_valid && s_out_ready;
    endtask

    task automatic step_p(input logic v, input logic [2:0] sel, input logic ordy,
                          output logic acc, output logic del);
        cyc++;
        p_in_valid = v; p_in_sel = sel; p_out_ready = ordy;
        #1;
        acc = p_in_valid && p_in_ready;
        del = p_out_valid && p_out_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({m_out_valid, m_out_data, m_out_sel, m_out_err} !== 13'h0) begin
            n_bad++;
            $display("FAIL reset_out: valid=%b data=%h sel=%0d err=%b, want all zero",
                     m_out_valid, m_out_data, m_out_sel, m_out_err);
        end
        n_cmp++;
        if (s_out_valid !== 1'b0 || p_out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid: dut6=%b dut0=%b, want 0 0", s_out_valid, p_out_valid);
        end
        n_cmp++;
        if (m_in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready: got %b want 1", m_in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic acc, del;
        exp_t e;
        for (int k = 0; k < 8; k++) m_in_data[k*8 +: 8] = 8'h10 + 8'(k);
        for (int t = 0; t < 40 && (t < 8 || q_m.size() > 0); t++) begin
            step_m(t < 8, 3'(t), 1'b1, acc, del);
            if (t < 8) begin
                n_cmp++;
                if (!acc) begin
                    n_bad++;
                    $display("FAIL b2b_accept: beat %0d not accepted, in_ready=%b", t, m_in_ready);
                end else begin
                    e.d = 8'h10 + 8'(t); e.s = 3'(t); e.e = 1'b0; e.c = cyc;
                    q_m.push_back(e);
                end
            end
            if (del) begin
                n_cmp++;
                if (q_m.size() == 0) begin
                    n_bad++;
                    $display("FAIL b2b_extra: unexpected beat data=%h", m_out_data);
                end else begin
                    e = q_m.pop_front();
                    if ({m_out_data, m_out_sel, m_out_err} !== {e.d, e.s, e.e}) begin
                        n_bad++;
                        $display("FAIL b2b_beat: got %h/%0d/%b want %h/%0d/%b",
                                 m_out_data, m_out_sel, m_out_err, e.d, e.s, e.e);
                    end
                    n_cmp++;
                    if (cyc - e.c != 3) begin
                        n_bad++;
                        $display("FAIL b2b_latency: got %0d want 3", cyc - e.c);
                    end
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (q_m.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_drain: %0d beats missing, want 0", q_m.size());
            q_m.delete();
        end
    endtask

    task automatic test_stall();
        logic acc, del, ordy;
        logic [7:0] frozen;
        int issued;
        exp_t e;
        issued = 0;
        frozen = '0;
        for (int t = 0; t < 80 && (issued < 16 || q_m.size() > 0); t++) begin
            m_in_data = {$urandom, $urandom};
            ordy = !(t >= 6 && t < 10);
            m_in_sel = 3'($urandom_range(0, 7));
            step_m(issued < 16, m_in_sel, ordy, acc, del);
            if (acc) begin
                e.d = m_in_data[m_in_sel*8 +: 8]; e.s = m_in_sel; e.e = 1'b0; e.c = cyc;
                q_m.push_back(e);
                issued++;
            end
            if (t == 6) frozen = m_out_data;
            if (t >= 6 && t < 10) begin
                n_cmp++;
                if (m_in_ready !== 1'b0 || m_out_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL stall_ready: cycle %0d in_ready=%b out_valid=%b want 0 1",
                             t, m_in_ready, m_out_valid);
                end
                n_cmp++;
                if (m_out_data !== frozen) begin
                    n_bad++;
                    $display("FAIL stall_frozen: cycle %0d data=%h want %h", t, m_out_data, frozen);
                end
            end
            if (del) begin
                n_cmp++;
                if (q_m.size() == 0) begin
                    n_bad++;
                    $display("FAIL stall_extra: unexpected beat data=%h", m_out_data);
                end else begin
                    e = q_m.pop_front();
                    if ({m_out_data, m_out_sel, m_out_err} !== {e.d, e.s, e.e}) begin
                        n_bad++;
                        $display("FAIL stall_beat: got %h/%0d/%b want %h/%0d/%b",
                                 m_out_data, m_out_sel, m_out_err, e.d, e.s, e.e);
                    end
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (q_m.size() != 0 || issued != 16) begin
            n_bad++;
            $display("FAIL stall_drain: pending=%0d issued=%0d want 0 16", q_m.size(), issued);
            q_m.delete();
        end
    endtask

    task automatic test_pad();
        logic acc, del;
        exp_t e;
        logic [2:0] sels [4] = '{3'd7, 3'd5, 3'd6, 3'd0};
        for (int k = 0; k < 6; k++) s_in_data[k*8 +: 8] = 8'h20 + 8'(k);
        for (int t = 0; t < 40 && (t < 4 || q_s.size() > 0); t++) begin
            step_s(t < 4, (t < 4) ? sels[t] : 3'd0, 1'b1, acc, del);
            if (acc) begin
                e.s = sels[t];
                e.e = (sels[t] >= 3'd6);
                e.d = e.e ? 8'h00 : s_in_data[sels[t]*8 +: 8];
                e.c = cyc;
                q_s.push_back(e);
            end
            if (del) begin
                n_cmp++;
                if (q_s.size() == 0) begin
                    n_bad++;
                    $display("FAIL pad_extra: unexpected beat data=%h", s_out_data);
                end else begin
                    e = q_s.pop_front();
                    if ({s_out_data, s_out_sel, s_out_err} !== {e.d, e.s, e.e}) begin
                        n_bad++;
                        $display("FAIL pad_beat: got %h/%0d/%b want %h/%0d/%b",
                                 s_out_data, s_out_sel, s_out_err, e.d, e.s, e.e);
                    end
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (q_s.size() != 0) begin
            n_bad++;
            $display("FAIL pad_drain: %0d beats missing, want 0", q_s.size());
            q_s.delete();
        end
    endtask

    task automatic test_mid_reset();
        logic acc, del, saw;
        exp_t e;
        for (int k = 0; k < 8; k++) m_in_data[k*8 +: 8] = 8'h10 + 8'(k);
        for (int t = 0; t < 3; t++) begin
            step_m(1'b1, 3'(t + 1), 1'b1, acc, del);
            @(negedge clk);
        end
        rst = 1'b1;
        step_m(1'b0, 3'd0, 1'b0, acc, del);
        @(posedge clk);
        #1;
        n_cmp++;
        if (m_out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_valid: got %b want 0", m_out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        for (int t = 0; t < 10; t++) begin
            step_m(t == 0, 3'd6, 1'b1, acc, del);
            if (acc) begin
                e.d = 8'h16; e.s = 3'd6; e.e = 1'b0; e.c = cyc;
                q_m.push_back(e);
            end
            if (del) begin
                n_cmp++;
                if (q_m.size() == 0) begin
                    n_bad++;
                    $display("FAIL midrst_stale: beat data=%h sel=%0d after reset", m_out_data, m_out_sel);
                end else begin
                    e = q_m.pop_front();
                    saw = 1'b1;
                    if ({m_out_data, m_out_sel} !== {e.d, e.s}) begin
                        n_bad++;
                        $display("FAIL midrst_beat: got %h/%0d want %h/%0d", m_out_data, m_out_sel, e.d, e.s);
                    end
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (!saw || q_m.size() != 0) begin
            n_bad++;
            $display("FAIL midrst_drain: saw=%b pending=%0d want 1 0", saw, q_m.size());
            q_m.delete();
        end
    endtask

`ifdef MUX_SCAN_EN
    task automatic test_scan();
        logic acc, del;
        int issued;
        exp_t e;
        issued = 0;
        for (int k = 0; k < 8; k++) m_in_data[k*8 +: 8] = 8'h10 + 8'(k);
        m_scan_en = 1'b1;
        for (int t = 0; t < 40 && (issued < 10 || q_m.size() > 0); t++) begin
            step_m(issued < 10, 3'($urandom_range(0, 7)), 1'b1, acc, del);
            if (acc) begin
                e.s = 3'(issued % 8); e.d = 8'h10 + 8'(issued % 8); e.e = 1'b0; e.c = cyc;
                q_m.push_back(e);
                issued++;
            end
            if (del) begin
                n_cmp++;
                if (q_m.size() == 0) begin
                    n_bad++;
                    $display("FAIL scan_extra: unexpected beat data=%h", m_out_data);
                end else begin
                    e = q_m.pop_front();
                    if ({m_out_data, m_out_sel, m_out_err} !== {e.d, e.s, e.e}) begin
                        n_bad++;
                        $display("FAIL scan_beat: got %h/%0d/%b want %h/%0d/%b",
                                 m_out_data, m_out_sel, m_out_err, e.d, e.s, e.e);
                    end
                end
            end
            @(negedge clk);
        end
        m_scan_en = 1'b0;
        n_cmp++;
        if (q_m.size() != 0) begin
            n_bad++;
            $display("FAIL scan_drain: %0d beats missing, want 0", q_m.size());
            q_m.delete();
        end
    endtask
`endif

    task automatic test_pipe_out_only();
        logic acc, del;
        exp_t e;
        logic [2:0] sels [3] = '{3'd3, 3'd0, 3'd7};
        for (int k = 0; k < 8; k++) p_in_data[k*8 +: 8] = 8'h10 + 8'(k);
        for (int t = 0; t < 20 && (t < 3 || q_p.size() > 0); t++) begin
            step_p(t < 3, (t < 3) ? sels[t] : 3'd0, 1'b1, acc, del);
            if (acc) begin
                e.s = sels[t]; e.d = 8'h10 + 8'(sels[t]); e.e = 1'b0; e.c = cyc;
                q_p.push_back(e);
            end
            if (del) begin
                n_cmp++;
                if (q_p.size() == 0) begin
                    n_bad++;
                    $display("FAIL pipe0_extra: unexpected beat data=%h", p_out_data);
                end else begin
                    e = q_p.pop_front();
                    if ({p_out_data, p_out_sel, p_out_err} !== {e.d, e.s, e.e}) begin
                        n_bad++;
                        $display("FAIL pipe0_beat: got %h/%0d/%b want %h/%0d/%b",
                                 p_out_data, p_out_sel, p_out_err, e.d, e.s, e.e);
                    end
                    n_cmp++;
                    if (cyc - e.c != 1) begin
                        n_bad++;
                        $display("FAIL pipe0_latency: got %0d want 1", cyc - e.c);
                    end
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (q_p.size() != 0) begin
            n_bad++;
            $display("FAIL pipe0_drain: %0d beats missing, want 0", q_p.size());
            q_p.delete();
        end
    endtask

    initial begin
        rst = 1'b1;
        m_in_data = '0; m_in_sel = '0; m_in_valid = 1'b0; m_scan_en = 1'b0; m_out_ready = 1'b1;
        s_in_data = '0; s_in_sel = '0; s_in_valid = 1'b0; s_out_ready = 1'b1;
        p_in_data = '0; p_in_sel = '0; p_in_valid = 1'b0; p_out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_stall();
        test_pad();
        test_mid_reset();
`ifdef MUX_SCAN_EN
        test_scan();
`endif
        test_pipe_out_only();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
